// File: rtl/n64_readcmd_tx.sv
// N64 console-side command transmitter: serialises an 8-bit command byte
// MSB first plus a stop bit using the 1 us / 3 us low-pulse encoding at 4 MHz.
`timescale 1ns/1ps
module n64_readcmd_tx #(
    parameter int unsigned LOW_SHORT  = 4,
    parameter int unsigned LOW_LONG   = 12,
    parameter int unsigned BIT_CYCLES = 16,
    parameter int unsigned STOP_HIGH  = 8
) (
    input  logic       clk_4M,
    input  logic       rst,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] cmd,
    output logic       dout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle,
        StBitLow,
        StBitHigh,
        StStopLow,
        StStopHigh
    } state_e;

    // Terminal sub_cnt values for each phase (phase lasts end+1 cycles).
    localparam logic [4:0] ShortEnd    = 5'(LOW_SHORT - 1);
    localparam logic [4:0] LongEnd     = 5'(LOW_LONG - 1);
    localparam logic [4:0] HighEndOne  = 5'(BIT_CYCLES - LOW_SHORT - 1);
    localparam logic [4:0] HighEndZero = 5'(BIT_CYCLES - LOW_LONG - 1);
    localparam logic [4:0] StopHighEnd = 5'(STOP_HIGH - 1);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [4:0] sub_cnt_q, sub_cnt_d;
    logic       dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cur_one;

    assign cur_one = shift_q[7];
    assign dout    = dout_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        sub_cnt_d = sub_cnt_q + 5'd1;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                sub_cnt_d = 5'd0;
                if (start && enable) begin
                    shift_d   = cmd;
                    bit_cnt_d = 3'd7;
                    state_d   = StBitLow;
                end
            end
            StBitLow: begin
                if (sub_cnt_q == (cur_one ? ShortEnd : LongEnd)) begin
                    sub_cnt_d = 5'd0;
                    state_d   = StBitHigh;
                end
            end
            StBitHigh: begin
                if (sub_cnt_q == (cur_one ? HighEndOne : HighEndZero)) begin
                    sub_cnt_d = 5'd0;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = StStopLow;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        state_d   = StBitLow;
                    end
                end
            end
            StStopLow: begin
                if (sub_cnt_q == ShortEnd) begin
                    sub_cnt_d = 5'd0;
                    state_d   = StStopHigh;
                end
            end
            StStopHigh: begin
                if (sub_cnt_q == StopHighEnd) begin
                    sub_cnt_d = 5'd0;
                    state_d   = StIdle;
                    done_d    = 1'b1;
                end
            end
            default: begin
                sub_cnt_d = 5'd0;
                state_d   = StIdle;
            end
        endcase

        // Dropping enable mid-frame abandons the frame silently.
        if (state_q != StIdle && !enable) begin
            state_d   = StIdle;
            shift_d   = 8'd0;
            bit_cnt_d = 3'd0;
            sub_cnt_d = 5'd0;
            done_d    = 1'b0;
        end

        dout_d = !(state_d == StBitLow || state_d == StStopLow);
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset releases the line immediately.
    always_ff @(posedge clk_4M or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            sub_cnt_q <= 5'd0;
            dout_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sub_cnt_q <= sub_cnt_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/n64_readcmd_tx.md
# n64_readcmd_tx

Console-side transmitter for the N64 controller serial line: serialises an 8-bit command byte (default 0x01, "read buttons") plus the console stop bit onto the single data wire, using the 1 µs / 3 µs pulse-width encoding at 4 MHz. It is the counterpart of `n64_readcmd_rx`: on `done` the line is released and the receiver captures the controller's 32-bit reply. Runs entirely in the `clk_4M` domain produced by `divM`.

## Interface
Parameters:
- `LOW_SHORT`, default 4: low cycles of a '1' bit and of the stop bit (1 µs).
- `LOW_LONG`, default 12: low cycles of a '0' bit (3 µs).
- `BIT_CYCLES`, default 16: total cycles per data bit (4 µs).
- `STOP_HIGH`, default 8: high cycles after the stop-bit low phase, before `done`.

Ports:
- `clk_4M`, input, 1: the single clock, 4 MHz.
- `rst`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: transmitter enable. Low aborts or blocks transmission.
- `start`, input, 1: request to send. Sampled on the `clk_4M` rising edge.
- `cmd`, input, 8: command byte, latched when `start` is accepted.
- `dout`, output, 1: line level. 0 drives low; 1 releases the line (idle).
- `busy`, output, 1: high while a frame is in progress.
- `done`, output, 1: one-cycle pulse when a frame has finished.

## Operation
- All outputs are registered.
- Reset values: `dout`=1, `busy`=0, `done`=0; FSM in IDLE; shift register and counters cleared.
- FSM states: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH.
- IDLE:
  - `dout`=1, `busy`=0.
  - `start`=1 and `enable`=1 at an edge: latch `cmd`, set `bit_cnt`=7 and `sub_cnt`=0, go to BIT_LOW, `busy`=1.
- BIT_LOW:
  - `dout`=0.
  - Stays for LOW_SHORT cycles if the current bit (MSB first) is 1, else LOW_LONG cycles; then go to BIT_HIGH.
- BIT_HIGH:
  - `dout`=1 for the remainder of the BIT_CYCLES period.
  - At the period end: if `bit_cnt`=0 go to STOP_LOW; otherwise decrement `bit_cnt`, shift the register left, go to BIT_LOW.
- STOP_LOW: `dout`=0 for LOW_SHORT cycles, then go to STOP_HIGH.
- STOP_HIGH: `dout`=1 for STOP_HIGH cycles, then go to IDLE with `done`=1 and `busy`=0 in the same cycle.
- `sub_cnt` is 5 bits wide; it resets to 0 at every phase and bit boundary.
- `start` is ignored while `busy`=1; no queuing.
- `cmd` changes after acceptance have no effect on the frame in progress.
- `enable` low in any non-IDLE state:
  - Next edge: go to IDLE, `dout`=1, `busy`=0.
  - No `done` pulse.
- `rst` asserted mid-frame: `dout` goes to 1 immediately (asynchronously); all other state returns to reset values.
- `start` and `enable` falling at the same edge: not accepted.

## Timing
Let edge E0 be the edge that accepts `start`. Cycle n is the interval from E0+n to E0+n+1.
- Data bit k (k=0 is the MSB) occupies cycles 16k .. 16k+15.
  - Low for cycles 16k .. 16k+L−1, where L=4 for a '1' and L=12 for a '0'.
  - High for the rest of the bit.
- Stop bit: low in cycles 128..131, high in cycles 132..139.
- Cycle 140:
  - `done`=1, `busy`=0, state is IDLE.
  - A `start` sampled at edge E0+141 begins the next frame, with its first low in cycle 141.
- `busy`=1 in cycles 0..139.
- Latency from `start` sampled to the first falling edge of `dout`: 1 edge; `dout`=0 from E0.
- Total frame: 140 cycles (35 µs), plus 1 `done` cycle.

## Test plan
- Reset:
  - Stimulus: hold `rst`=1, toggle `clk_4M`; then release.
  - Required: `dout`=1, `busy`=0, `done`=0 throughout; with `start`=0 they stay so for 100 cycles.
- Default command:
  - Stimulus: `cmd`=0x01, one-cycle `start`.
  - Required:
    - Seven '0' bits, each 12 low / 4 high.
    - One '1' bit, 4 low / 12 high.
    - Stop bit: 4 low, 8 high.
    - `done` pulses exactly at cycle 140; `busy` high for 140 cycles.
- All-ones and all-zeros patterns:
  - Stimulus: `cmd`=0xFF, then `cmd`=0x00, sent back to back with `start` asserted on the `done` cycle + 1.
  - Required: correct pulse widths; second frame starts at cycle 141 of the first frame.
- Start during busy:
  - Stimulus: `cmd`=0xA5; pulse `start` again with `cmd`=0x00 at cycle 50.
  - Required: the wire carries 0xA5 unchanged; exactly one `done`.
- Abort:
  - Stimulus: drop `enable` at cycle 70.
  - Required: `dout`=1 and `busy`=0 after the next edge; no `done`; the next `start` sends a full frame.
- Asynchronous reset mid-frame:
  - Stimulus: assert `rst` between edges during a low phase (cycle 20).
  - Required: `dout` rises before the next clock edge; the FSM is in IDLE after `rst` releases.
